// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bundle for inst_fetch.
// master = fetch unit, slave = instruction memory.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch stage with redirect/flush handling.
// Define INST_FETCH_ALIGN_CHK_EN to halt and flag misaligned redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master imem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         id_ready,
    output logic         id_valid,
    output logic [31:0]  id_inst,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_pc4,
    output logic         fetch_fault
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fault_q, fault_d;

    logic [31:0] redir_pc;
    logic        redir_bad;
    logic        req_valid;
    logic        req_hs;
    logic        rsp;

    // The PC register never holds a misaligned value, even when faulted.
    assign redir_pc = {redirect_pc[31:2], 2'b00};

`ifdef INST_FETCH_ALIGN_CHK_EN
    assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign redir_bad = 1'b0;
`endif

    assign req_valid = (state_q == S_REQ) && !fault_q && !rst;
    assign req_hs    = req_valid && imem.imem_req_ready;
    assign rsp       = imem.imem_rsp_valid;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;

    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc4      = id_pc_q + 32'd4;
    assign fetch_fault = fault_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            // A request accepted or still in flight must be drained.
            pc_d       = redir_pc;
            id_valid_d = 1'b0;
            fault_d    = redir_bad;
            unique case (state_q)
                S_REQ:  state_d = req_hs ? S_DROP : S_REQ;
                S_WAIT: state_d = rsp ? S_REQ : S_DROP;
                S_DROP: state_d = rsp ? S_REQ : S_DROP;
                S_HOLD: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp) begin
                        id_inst_d  = imem.imem_rsp_data;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (rsp) begin
                        state_d = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (id_valid_q && id_ready) begin
                        id_valid_d = 1'b0;
                        state_d    = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'h0;
            id_pc_q    <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a
// randomized run checked against a sequential-stream reference model.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        fetch_fault;

    inst_fetch_if mif();

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (mif),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_pc4        (id_pc4),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int step_cyc = 0;

    // memory / consumer knobs
    int   lat = 1;
    bit   rdy_rand = 1'b0;
    bit   idr_rand = 1'b0;
    logic rdy_knob = 1'b1;
    logic idr_knob = 1'b1;
    logic [31:0] spec_addr = 32'hFFFF_FFFF;
    logic [31:0] spec_data = 32'h0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // per-step observations
    bit          acc, con, multi, stall;
    logic [31:0] acc_addr, con_pc, con_inst, con_pc4;
    logic [31:0] st_pc, st_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == spec_addr) return spec_data;
        return (a ^ 32'h5A5A_0013) + {a[15:0], 16'h0};
    endfunction

    function automatic logic [31:0] mask_pc(input logic [31:0] a);
`ifdef INST_FETCH_ALIGN_CHK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic step(input bit rv = 1'b0,
                        input logic [31:0] rpc = 32'h0);
        @(negedge clk);
        step_cyc = cyc;
        redirect_valid = rv;
        redirect_pc = rpc;
        id_ready = idr_rand ? ($urandom_range(0, 9) < 6) : idr_knob;
        mif.imem_req_ready =
            rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_knob;
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data = 32'hDEAD_BEEF;
        if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mif.imem_rsp_valid = 1'b1;
            mif.imem_rsp_data = inst_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        acc = mif.imem_req_valid && mif.imem_req_ready;
        acc_addr = mif.imem_req_addr;
        multi = acc && (pend_addr.size() > 0);
        if (acc) begin
            pend_addr.push_back(acc_addr);
            pend_due.push_back(cyc + lat);
        end
        con = id_valid && id_ready && !rv;
        con_pc = id_pc;
        con_inst = id_inst;
        con_pc4 = id_pc4;
        stall = id_valid && !id_ready && !rv;
        st_pc = id_pc;
        st_inst = id_inst;
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input bit keep);
        rst = 1'b1;
        if (!keep) begin
            pend_addr.delete();
            pend_due.delete();
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 1;
        rst = 1'b1;
        step();
        checks++;
        if (mif.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_req_valid got=%b exp=0", mif.imem_req_valid);
        end
        checks++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL rst_id got=%b/%h/%h exp=0/0/0",
                     id_valid, id_inst, id_pc);
        end
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL rst_fault got=%b exp=0", fetch_fault);
        end
        rst = 1'b0;
        step();
        checks++;
        if (!acc || acc_addr !== RPC) begin
            failures++;
            $display("FAIL first_req got=%b/%h exp=1/%h", acc, acc_addr, RPC);
        end
        // abandon the fetch; its stale response arrives after reset
        spec_addr = RPC;
        spec_data = 32'hBAD0_0001;
        do_reset(1'b1);
        rdy_knob = 1'b0;
        step();
        spec_addr = 32'hFFFF_FFFF;
        checks++;
        if (id_valid !== 1'b0 || mif.imem_req_valid !== 1'b1
            || mif.imem_req_addr !== RPC) begin
            failures++;
            $display("FAIL stale_rsp got=%b/%b/%h exp=0/1/%h", id_valid,
                     mif.imem_req_valid, mif.imem_req_addr, RPC);
        end
        rdy_knob = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (con) break;
        end
        checks++;
        if (!con || con_pc !== RPC || con_inst !== inst_of(RPC)) begin
            failures++;
            $display("FAIL post_rst_fetch got=%b/%h/%h exp=1/%h/%h",
                     con, con_pc, con_inst, RPC, inst_of(RPC));
        end
    endtask

    task automatic test_sequential();
        int acyc[$];
        logic [31:0] aadr[$];
        logic [31:0] cpc[$];
        int c0;
        do_reset(1'b0);
        lat = 1;
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            step();
            if (acc) begin
                acyc.push_back(step_cyc - c0);
                aadr.push_back(acc_addr);
            end
            if (con) begin
                cpc.push_back(con_pc);
                checks++;
                if (con_pc4 !== con_pc + 32'd4
                    || con_inst !== inst_of(con_pc)) begin
                    failures++;
                    $display("FAIL seq_id got=%h/%h exp=%h/%h", con_pc4,
                             con_inst, con_pc + 32'd4, inst_of(con_pc));
                end
            end
        end
        checks++;
        if (acyc.size() != 3 || cpc.size() != 3) begin
            failures++;
            $display("FAIL seq_count got=%0d/%0d exp=3/3",
                     acyc.size(), cpc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (acyc[k] != 3 * k || aadr[k] !== RPC + 32'(4 * k)
                    || cpc[k] !== RPC + 32'(4 * k)) begin
                    failures++;
                    $display("FAIL seq_req%0d got=%0d/%h/%h exp=%0d/%h",
                             k, acyc[k], aadr[k], cpc[k], 3 * k,
                             RPC + 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_req_stall();
        bit found = 1'b0;
        int n_acc8 = 0;
        int n_con8 = 0;
        bit held = 1'b1;
        do_reset(1'b0);
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (mif.imem_req_valid && mif.imem_req_addr == RPC + 32'h8) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_reach got=0 exp=1");
        end
        rdy_knob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mif.imem_req_valid !== 1'b1
                || mif.imem_req_addr !== RPC + 32'h8) held = 1'b0;
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL stall_hold got=%b/%h exp=1/%h",
                     mif.imem_req_valid, mif.imem_req_addr, RPC + 32'h8);
        end
        rdy_knob = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acc && acc_addr == RPC + 32'h8) n_acc8++;
            if (con && con_pc == RPC + 32'h8) n_con8++;
        end
        checks++;
        if (n_acc8 != 1 || n_con8 != 1) begin
            failures++;
            $display("FAIL stall_dup got=%0d/%0d exp=1/1", n_acc8, n_con8);
        end
    endtask

    task automatic test_hold();
        bit stable = 1'b1;
        do_reset(1'b0);
        spec_addr = RPC;
        spec_data = 32'h0050_0093;
        idr_knob = 1'b0;
        rdy_knob = 1'b1;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (id_valid) break;
        end
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093
            || id_pc !== RPC || id_pc4 !== RPC + 32'd4) begin
            failures++;
            $display("FAIL hold_load got=%b/%h/%h/%h exp=1/00500093/%h",
                     id_valid, id_inst, id_pc, id_pc4, RPC);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093
                || id_pc !== RPC || mif.imem_req_valid !== 1'b0 || acc)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL hold_stable got=%b/%h/%b exp=1/00500093/0",
                     id_valid, id_inst, mif.imem_req_valid);
        end
        idr_knob = 1'b1;
        step();
        checks++;
        if (!con || con_pc !== RPC) begin
            failures++;
            $display("FAIL hold_consume got=%b/%h exp=1/%h", con, con_pc, RPC);
        end
        step();
        checks++;
        if (!acc || acc_addr !== RPC + 32'd4) begin
            failures++;
            $display("FAIL hold_resume got=%b/%h exp=1/%h",
                     acc, acc_addr, RPC + 32'd4);
        end
        spec_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_redirect_wait();
        bit quiet = 1'b1;
        do_reset(1'b0);
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 3;
        step();
        checks++;
        if (!acc || acc_addr !== RPC) begin
            failures++;
            $display("FAIL rw_acc got=%b/%h exp=1/%h", acc, acc_addr, RPC);
        end
        lat = 1;
        step(1'b1, 32'h100);
        if (id_valid !== 1'b0 || mif.imem_req_valid !== 1'b0) quiet = 1'b0;
        step();
        if (id_valid !== 1'b0 || mif.imem_req_valid !== 1'b0) quiet = 1'b0;
        step();
        if (id_valid !== 1'b0) quiet = 1'b0;
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL rw_drop got=%b/%b exp=0/0",
                     id_valid, mif.imem_req_valid);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (con) break;
        end
        checks++;
        if (!con || con_pc !== 32'h100 || con_inst !== inst_of(32'h100)) begin
            failures++;
            $display("FAIL rw_next got=%b/%h/%h exp=1/100/%h",
                     con, con_pc, con_inst, inst_of(32'h100));
        end
    endtask

    task automatic test_redirect_rsp();
        do_reset(1'b0);
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 1;
        step();
        step(1'b1, 32'h240);
        checks++;
        if (id_valid !== 1'b0 || mif.imem_req_valid !== 1'b1
            || mif.imem_req_addr !== 32'h240) begin
            failures++;
            $display("FAIL rr_same got=%b/%b/%h exp=0/1/240", id_valid,
                     mif.imem_req_valid, mif.imem_req_addr);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (con) break;
        end
        checks++;
        if (!con || con_pc !== 32'h240) begin
            failures++;
            $display("FAIL rr_next got=%b/%h exp=1/240", con, con_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs[$];
        logic [31:0] p4s[$];
        do_reset(1'b0);
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 1;
        step(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && pcs.size() < 2; i++) begin
            step();
            if (con) begin
                pcs.push_back(con_pc);
                p4s.push_back(con_pc4);
            end
        end
        checks++;
        if (pcs.size() != 2) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=2", pcs.size());
        end else begin
            checks++;
            if (pcs[0] !== 32'hFFFF_FFFC || p4s[0] !== 32'h0
                || pcs[1] !== 32'h0) begin
                failures++;
                $display("FAIL wrap got=%h/%h/%h exp=fffffffc/0/0",
                         pcs[0], p4s[0], pcs[1]);
            end
        end
    endtask

    task automatic test_align();
        do_reset(1'b0);
        rdy_knob = 1'b1;
        idr_knob = 1'b1;
        lat = 3;
        step();
        step(1'b1, 32'h102);
`ifdef INST_FETCH_ALIGN_CHK_EN
        begin
            int busy = 0;
            checks++;
            if (fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
                failures++;
                $display("FAIL al_fault got=%b/%b exp=1/0",
                         fetch_fault, id_valid);
            end
            lat = 1;
            for (int i = 0; i < 8; i++) begin
                step();
                if (acc || id_valid || mif.imem_req_valid
                    || fetch_fault !== 1'b1) busy++;
            end
            checks++;
            if (busy != 0 || pend_addr.size() != 0) begin
                failures++;
                $display("FAIL al_halt got=%0d/%0d exp=0/0",
                         busy, pend_addr.size());
            end
            step(1'b1, 32'h200);
            checks++;
            if (fetch_fault !== 1'b0) begin
                failures++;
                $display("FAIL al_clear got=%b exp=0", fetch_fault);
            end
            for (int i = 0; i < 10; i++) begin
                step();
                if (acc) break;
            end
            checks++;
            if (!acc || acc_addr !== 32'h200) begin
                failures++;
                $display("FAIL al_resume got=%b/%h exp=1/200", acc, acc_addr);
            end
        end
`else
        checks++;
        if (fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL al_nofault got=%b exp=0", fetch_fault);
        end
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc) break;
        end
        checks++;
        if (!acc || acc_addr !== 32'h100) begin
            failures++;
            $display("FAIL al_mask got=%b/%h exp=1/100", acc, acc_addr);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] rpc;
        int ncons = 0;
        bit rv;
        do_reset(1'b0);
        rdy_rand = 1'b1;
        idr_rand = 1'b1;
        exp_pc = RPC;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            rv = ($urandom_range(0, 31) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef INST_FETCH_ALIGN_CHK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            step(rv, rpc);
            if (multi) begin
                checks++;
                failures++;
                $display("FAIL rnd_outstanding got=%0d exp=0", 2);
            end
            if (con) begin
                ncons++;
                checks++;
                if (con_pc !== exp_pc || con_inst !== inst_of(exp_pc)
                    || con_pc4 !== exp_pc + 32'd4) begin
                    failures++;
                    $display("FAIL rnd_stream got=%h/%h/%h exp=%h/%h/%h",
                             con_pc, con_inst, con_pc4, exp_pc,
                             inst_of(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (rv) exp_pc = mask_pc(rpc);
            if (stall) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== st_pc
                    || id_inst !== st_inst) begin
                    failures++;
                    $display("FAIL rnd_stable got=%b/%h/%h exp=1/%h/%h",
                             id_valid, id_pc, id_inst, st_pc, st_inst);
                end
            end
        end
        checks++;
        if (ncons < 100) begin
            failures++;
            $display("FAIL rnd_progress got=%0d exp>=100", ncons);
        end
        rdy_rand = 1'b0;
        idr_rand = 1'b0;
    endtask

    initial begin
        mif.imem_req_ready = 1'b0;
        mif.imem_rsp_valid = 1'b0;
        mif.imem_rsp_data = 32'h0;
        test_reset();
        test_sequential();
        test_req_stall();
        test_hold();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
